// File: rtl/bus_pkg.sv
// +----------------------------------------------------------------------------+
// | bus_pkg : shared scheduler types, round-robin helper and bus id constants  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    HOLD = 2'd2
  } sched_st_t;

  localparam int         RR_MAX    = 32;
  localparam logic [7:0] broadcast = 8'hFF;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // Behavioural form of the rotate-priority pick, for callers without a fixed width.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input logic [4:0]        ptr,
                                       input int                n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      if (k <= n && !r.found) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (req[j]) begin
          r.found = 1'b1;
          r.idx   = 5'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick_comb.sv
// +----------------------------------------------------------------------------+
// | rr_pick_comb : rotate-priority encoder, first request after ptr wins       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick_comb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);

  localparam int IW = $clog2(N);

  logic [N-1:0] rot;
  int           start;
  int           src;
  int           off;
  int           sum;

  always_comb begin
    start = (int'(ptr_i) == N-1) ? 0 : int'(ptr_i) + 1;
    rot   = '0;
    for (int k = 0; k < N; k++) begin
      src = start + k;
      if (src >= N) src = src - N;
      rot[k] = req_i[src];
    end
    // Scan downwards so the lowest rotated position is the last one written.
    found_o = 1'b0;
    off     = 0;
    for (int k = N-1; k >= 0; k--) begin
      if (rot[k]) begin
        found_o = 1'b1;
        off     = k;
      end
    end
    sum = start + off;
    if (sum >= N) sum = sum - N;
    idx_o = IW'(sum);
  end

endmodule

`default_nettype wire

// File: rtl/bus_rr_sched.sv
// +----------------------------------------------------------------------------+
// | bus_rr_sched : round-robin pop/hold bus grant scheduler with timeout      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module bus_rr_sched
  import bus_pkg::*;
#(
  parameter int drvrs      = 4,
  parameter int xfer_to    = 16,
  parameter int starve_lim = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic                     stall,
  input  logic                     xfer_done,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         gnt,
  output logic [$clog2(drvrs)-1:0] gnt_id,
  output logic                     gnt_vld,
  output logic                     tmo_err,
  output logic [drvrs-1:0]         starve
);

  localparam int IW = $clog2(drvrs);
  localparam int TW = $clog2(xfer_to);
  localparam int SW = $clog2(starve_lim + 1);

  sched_st_t        state_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    gnt_id_q;
  logic [drvrs-1:0] gnt_q;
  logic [drvrs-1:0] pop_q;
  logic             gnt_vld_q;
  logic             tmo_err_q;
  logic [TW-1:0]    tmo_q;

  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic [drvrs-1:0] pick_oh;

  rr_pick_comb #(
    .N (drvrs)
  ) u_pick (
    .req_i   (pndng),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign pick_oh = {{(drvrs-1){1'b0}}, 1'b1} << pick_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(drvrs - 1);
      gnt_id_q  <= '0;
      gnt_q     <= '0;
      pop_q     <= '0;
      gnt_vld_q <= 1'b0;
      tmo_err_q <= 1'b0;
      tmo_q     <= '0;
    end else begin
      pop_q     <= '0;
      tmo_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found && !stall) begin
            gnt_q     <= pick_oh;
            pop_q     <= pick_oh;
            gnt_id_q  <= pick_idx;
            gnt_vld_q <= 1'b1;
            state_q   <= POP;
          end
        end
        POP: begin
          tmo_q   <= '0;
          state_q <= HOLD;
        end
        HOLD: begin
          // Completion wins over a coincident timeout: no error is flagged then.
          if (xfer_done || tmo_q == TW'(xfer_to - 1)) begin
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= gnt_id_q;
            tmo_err_q <= !xfer_done;
            state_q   <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < drvrs; i++) begin : g_starve
    logic [SW-1:0] cnt_q;
    logic [SW-1:0] cnt_d;
    logic          flag_q;
    logic          flag_d;

    always_comb begin
      cnt_d  = cnt_q;
      flag_d = flag_q;
      if (gnt_q[i] || !pndng[i]) begin
        cnt_d = '0;
      end else if (cnt_q != SW'(starve_lim)) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == SW'(starve_lim)) flag_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q  <= '0;
        flag_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        flag_q <= flag_d;
      end
    end

    assign starve[i] = flag_q;
  end

  assign pop     = pop_q;
  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = gnt_vld_q;
  assign tmo_err = tmo_err_q;

endmodule

`default_nettype wire
